uart_rx_cfg: RTL
================

// Module: uart_rx_cfg
// PURPOSE
//  Parametrised UART receiver. Successor to the fixed 8N1 receiver in the baseband front end.
//  Configurable data width, parity and stop bits. Oversampled, majority-voted bit decisions.
//  Per-frame parity/framing status and a valid/ready output with overrun detection.
//  Sits between the pad-level uart_rx_i line and the message/packet assembler.
// PARAMETERS
//  CLK_FREQ_HZ  100_000_000  system clock frequency
//  BAUD         9600         line rate, bits/s
//  DATA_BITS    8            data bits per frame; legal 5..9; LSB first
//  PARITY       0            0 = none, 1 = odd, 2 = even
//  STOP_BITS    1            1 or 2
//  OVERSAMPLE   16           sample ticks per bit; even, >= 8
//  (derived) DIV = round(CLK_FREQ_HZ / (BAUD*OVERSAMPLE)); must be >= 2; elaboration error otherwise
// PORTS
//  clk           in   1          system clock
//  rst_n         in   1          asynchronous active-low reset
//  uart_rx_i     in   1          asynchronous serial line, idle high
//  rx_data_o     out  DATA_BITS  received word, stable while rx_valid_o=1
//  rx_valid_o    out  1          word + status available; held until accepted
//  rx_ready_i    in   1          consumer accepts when rx_valid_o & rx_ready_i
//  parity_err_o  out  1          status of the held word; meaningful only with rx_valid_o
//  frame_err_o   out  1          status of the held word: a stop bit was sampled 0
//  overrun_o     out  1          1-cycle pulse: frame completed while rx_valid_o=1 and not accepted
//  busy_o        out  1          1 in any state other than IDLE
// BEHAVIOUR
//  Reset: all outputs 0, except rx_data_o = 0. Synchroniser flops = 1. FSM = IDLE. Counters = 0.
//  Reset asserted mid-frame aborts immediately; the partial word is discarded.
//  Input: 2-flop synchroniser, then a 3rd flop for edge detect. Falling edge in IDLE starts a frame.
//  Tick gen: counter 0..DIV-1; tick on wrap. Restarted at 0 on the start edge, so phase aligns to the edge.
//    Free-running otherwise.
//  Per bit: sample counter 0..OVERSAMPLE-1 on ticks. Sample line at OS/2-1, OS/2, OS/2+1.
//    Bit value = majority of the 3 samples. Decision is made at the tick where count = OS/2+1.
//    Bit ends at count = OVERSAMPLE-1.
//  FSM: IDLE -> START -> DATA -> [PARITY if PARITY!=0] -> STOP -> IDLE. Also STOP -> BREAK -> IDLE.
//   START:  voted value 1 -> false start, back to IDLE, no output. Voted 0 -> DATA at bit end.
//   DATA:   shift in DATA_BITS bits LSB first; bit index 0..DATA_BITS-1; then PARITY or STOP.
//   PARITY: perr = (xor(data) ^ parity_bit) != (PARITY==1).
//           Odd: total number of ones incl. parity bit must be odd.
//   STOP:   STOP_BITS samples; ferr = any stop sample 0.
//           Complete at the decision point of the last stop bit (not bit end), for resync margin.
//   BREAK:  entered when ferr; waits for synchronised line = 1, then IDLE. No new start meanwhile.
//  Completion, in the cycle after the final stop decision:
//   - rx_valid_o=0, or rx_ready_i=1 in that cycle:
//       load rx_data_o/parity_err_o/frame_err_o; rx_valid_o=1.
//   - else: new word dropped; held word and status unchanged; overrun_o=1 for 1 cycle.
//  Words with perr/ferr are still delivered, with their flags set.
//  Handshake: rx_valid_o falls the cycle after rx_valid_o & rx_ready_i, unless reloaded in that same cycle.
//    Output is never combinationally dependent on rx_ready_i.
//  Latency: start edge at synchroniser output to rx_valid_o rise
//    = (1 + DATA_BITS + P + STOP_BITS - 1) bits + (OS/2+1)*DIV + 2 clk; P = 1 if parity enabled, else 0.
//  Widths: tick counter $clog2(DIV); sample counter $clog2(OVERSAMPLE); bit index $clog2(DATA_BITS+1).
// STRUCTURE
//  uart_pkg: state enum (IDLE, START, DATA, PARITY, STOP, BREAK); parity mode constants;
//    function calc_div(clk, baud, os).
//  Sub-module uart_baud_tick (DIV param; inputs restart, enable; output tick). Shared with the future TX.
//  Top: synchroniser, FSM, shift register, output register/handshake.
// TESTING  (cfg CLK_FREQ_HZ=16_000_000 BAUD=250_000 OS=16 -> DIV=4, 64 clk/bit, unless stated)
//  1. 8N1, send 0xA5, rx_ready_i=1 -> rx_data_o=0xA5; rx_valid_o high 1 clk; perr=ferr=0; no overrun.
//  2. 8E1, send 0x37 with parity bit 0 (correct=1) -> rx_data_o=0x37, parity_err_o=1. Repeat with 1 -> 0.
//  3. 8N2, send 0x55 with 2nd stop bit 0, line low 3 more bits
//       -> frame_err_o=1; busy_o stays 1 until line high; the next 0x0F is received cleanly.
//  4. Low glitch of 20 clk (< half bit) in IDLE -> FSM returns to IDLE; no rx_valid_o.
//     Single-sample 1-clk spike inside a data bit -> voted value unaffected.
//  5. rx_ready_i=0; send 0x11 then 0x22 -> rx_data_o stays 0x11; overrun_o 1-clk pulse at 0x22 completion;
//     then rx_ready_i=1 -> rx_valid_o drops the next clk. Also: accept and completion in the same clk -> 0x22 loaded, no overrun.
//  6. 9O1, DATA_BITS=9, send 0x1A3; assert rst_n=0 mid data bit 4 -> outputs reset asynchronously.
//     After release, 0x0C6 is received correctly with parity_err_o=0.

Source files
------------

// File: rtl/uart_pkg.sv
// rtl/uart_pkg.sv - shared types, parity modes and divider helper for the UART blocks
package uart_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_START,
        ST_DATA,
        ST_PARITY,
        ST_STOP,
        ST_BREAK
    } rx_state_t;

    localparam int PAR_NONE = 0;
    localparam int PAR_ODD  = 1;
    localparam int PAR_EVEN = 2;

    // Rounded clock divider giving OVERSAMPLE ticks per bit.
    function automatic int calc_div(input int clk_hz, input int baud, input int os);
        return (clk_hz + (baud * os) / 2) / (baud * os);
    endfunction

endpackage

// File: rtl/uart_baud_tick.sv
// rtl/uart_baud_tick.sv - oversample tick generator, phase-restartable
module uart_baud_tick #(
    parameter int DIV = 4
) (
    input  logic clk,
    input  logic rst_n,
    input  logic restart,
    input  logic enable,
    output logic tick
);

    localparam int CW = (DIV > 1) ? $clog2(DIV) : 1;
    localparam logic [CW-1:0] LAST = CW'(DIV - 1);

    logic [CW-1:0] cnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt <= '0;
        end else if (restart) begin
            cnt <= '0;
        end else if (enable) begin
            cnt <= (cnt == LAST) ? '0 : cnt + 1'b1;
        end
    end

    assign tick = enable & ~restart & (cnt == LAST);

endmodule

// File: rtl/uart_rx_cfg.sv
// rtl/uart_rx_cfg.sv - oversampled, configurable-frame UART receiver with valid/ready output
module uart_rx_cfg
    import uart_pkg::*;
#(
    parameter int CLK_FREQ_HZ = 100_000_000,
    parameter int BAUD        = 9600,
    parameter int DATA_BITS   = 8,
    parameter int PARITY      = 0,
    parameter int STOP_BITS   = 1,
    parameter int OVERSAMPLE  = 16
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 uart_rx_i,
    output logic [DATA_BITS-1:0] rx_data_o,
    output logic                 rx_valid_o,
    input  logic                 rx_ready_i,
    output logic                 parity_err_o,
    output logic                 frame_err_o,
    output logic                 overrun_o,
    output logic                 busy_o
);

    localparam int DIV = calc_div(CLK_FREQ_HZ, BAUD, OVERSAMPLE);
    localparam int SW  = $clog2(OVERSAMPLE);
    localparam int BW  = $clog2(DATA_BITS + 1);

    localparam logic [SW-1:0] S_PRE = SW'(OVERSAMPLE / 2 - 1);
    localparam logic [SW-1:0] S_MID = SW'(OVERSAMPLE / 2);
    localparam logic [SW-1:0] S_DEC = SW'(OVERSAMPLE / 2 + 1);
    localparam logic [SW-1:0] S_END = SW'(OVERSAMPLE - 1);
    localparam logic [BW-1:0] DATA_END  = BW'(DATA_BITS);
    localparam logic [BW-1:0] LAST_STOP = BW'(STOP_BITS - 1);

    generate
        if (DIV < 2) begin : g_bad_div
            $error("uart_rx_cfg: clock divider below 2");
        end
        if (PARITY != PAR_NONE && PARITY != PAR_ODD && PARITY != PAR_EVEN) begin : g_bad_par
            $error("uart_rx_cfg: illegal parity mode");
        end
    endgenerate

    logic sync1, sync2, sync3;
    logic rx_s, fall;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1 <= 1'b1;
            sync2 <= 1'b1;
            sync3 <= 1'b1;
        end else begin
            sync1 <= uart_rx_i;
            sync2 <= sync1;
            sync3 <= sync2;
        end
    end

    assign rx_s = sync2;
    assign fall = sync3 & ~sync2;

    rx_state_t            state, state_nxt;
    logic                 tick, restart, complete;
    logic [SW-1:0]        scnt, scnt_inc;
    logic [BW-1:0]        bidx;
    logic [1:0]           smp;
    logic                 vote, at_dec, at_end;
    logic [DATA_BITS-1:0] shreg;
    logic                 perr_q, ferr_q, done_q, done_ferr;

    uart_baud_tick #(.DIV(DIV)) u_tick (
        .clk     (clk),
        .rst_n   (rst_n),
        .restart (restart),
        .enable  (1'b1),
        .tick    (tick)
    );

    // The start edge counts as sample 0, so actions key on the post-increment count.
    assign scnt_inc = (scnt == S_END) ? '0 : scnt + 1'b1;
    assign at_dec   = tick & (scnt_inc == S_DEC);
    assign at_end   = tick & (scnt_inc == S_END);
    assign vote     = (smp[1] & smp[0]) | (smp[1] & rx_s) | (smp[0] & rx_s);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        restart   = 1'b0;
        complete  = 1'b0;
        case (state)
            ST_IDLE: begin
                if (fall) begin
                    state_nxt = ST_START;
                    restart   = 1'b1;
                end
            end
            ST_START: begin
                if (at_dec && vote) begin
                    state_nxt = ST_IDLE;
                end else if (at_end) begin
                    state_nxt = ST_DATA;
                end
            end
            ST_DATA: begin
                if (at_end && bidx == DATA_END) begin
                    state_nxt = (PARITY != PAR_NONE) ? ST_PARITY : ST_STOP;
                end
            end
            ST_PARITY: begin
                if (at_end) begin
                    state_nxt = ST_STOP;
                end
            end
            ST_STOP: begin
                // Finish mid-bit so the next start edge is never missed.
                if (at_dec && bidx == LAST_STOP) begin
                    complete  = 1'b1;
                    state_nxt = (ferr_q | ~vote) ? ST_BREAK : ST_IDLE;
                end
            end
            ST_BREAK: begin
                if (rx_s) begin
                    state_nxt = ST_IDLE;
                end
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            scnt      <= '0;
            bidx      <= '0;
            smp       <= 2'b11;
            shreg     <= '0;
            perr_q    <= 1'b0;
            ferr_q    <= 1'b0;
            done_q    <= 1'b0;
            done_ferr <= 1'b0;
        end else begin
            done_q <= complete;
            if (complete) begin
                done_ferr <= ferr_q | ~vote;
            end
            if (restart) begin
                scnt   <= '0;
                bidx   <= '0;
                perr_q <= 1'b0;
                ferr_q <= 1'b0;
            end else if (tick) begin
                scnt <= scnt_inc;
                if (scnt_inc == S_PRE) smp[1] <= rx_s;
                if (scnt_inc == S_MID) smp[0] <= rx_s;
                if (at_end && state_nxt != state) bidx <= '0;
                if (at_dec) begin
                    case (state)
                        ST_DATA: begin
                            shreg <= {vote, shreg[DATA_BITS-1:1]};
                            bidx  <= bidx + 1'b1;
                        end
                        ST_PARITY: perr_q <= (^shreg ^ vote) != (PARITY == PAR_ODD);
                        ST_STOP: begin
                            ferr_q <= ferr_q | ~vote;
                            bidx   <= bidx + 1'b1;
                        end
                        default: ;
                    endcase
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rx_data_o    <= '0;
            rx_valid_o   <= 1'b0;
            parity_err_o <= 1'b0;
            frame_err_o  <= 1'b0;
            overrun_o    <= 1'b0;
        end else begin
            overrun_o <= 1'b0;
            if (done_q && (!rx_valid_o || rx_ready_i)) begin
                rx_data_o    <= shreg;
                parity_err_o <= perr_q;
                frame_err_o  <= done_ferr;
                rx_valid_o   <= 1'b1;
            end else begin
                if (done_q) overrun_o <= 1'b1;
                if (rx_valid_o && rx_ready_i) rx_valid_o <= 1'b0;
            end
        end
    end

    assign busy_o = (state != ST_IDLE);

endmodule
